// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//
// APB3 initiator. It accepts single-beat read/write commands on a valid/ready
// request channel, runs one APB transfer per command (SETUP then ACCESS with
// PREADY wait states), and returns read data plus error status on a
// valid/ready response channel. Only one transfer is in flight at a time.
//
// Optional build macro: APB_MASTER_TIMEOUT_EN
//   When defined, an ACCESS phase that sees TIMEOUT_CYCLES wait states aborts
//   with rsp_err=1 and rsp_timeout=1. When undefined, ACCESS waits for PREADY
//   indefinitely and rsp_timeout is constant 0.
//
// Parameters
//   ADDR_W          request address / PADDR width (must be > 2)
//   DATA_W          write data, read data, PWDATA and PRDATA width
//   TIMEOUT_CYCLES  ACCESS wait states before abort (1..65535, timeout build)
//
// Ports
//   PCLK, PRESETN         clock (rising edge) and async active-low reset
//   req_valid/req_ready   command handshake; req_ready is high only in IDLE
//   req_write             1 = write, 0 = read
//   req_addr, req_wdata   byte address (word aligned on capture), write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data; 0 for writes and aborted transfers
//   rsp_err               PSLVERR sampled high, or timeout
//   rsp_timeout           transfer aborted by timeout
//   busy                  high whenever the FSM is not in IDLE
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB master outputs
//   PRDATA, PREADY, PSLVERR                APB slave inputs
// -----------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Masking with a constant keeps every address bit in use while forcing
  // word alignment of the captured address.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              tmo_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_COUNT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wait_cnt;
  logic        tmo_q;

  // Terminal count only aborts when the slave is still stalling; a PREADY in
  // the same cycle wins and completes the transfer normally.
  assign tmo_hit = (wait_cnt == TMO_COUNT) && !PREADY;

  // Wait-state counter: cleared in SETUP so it starts at 0 on ACCESS entry.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wait_cnt <= '0;
    end else if (state_q == ST_SETUP) begin
      wait_cnt <= '0;
    end else if (state_q == ST_ACCESS && !PREADY) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      tmo_q <= 1'b0;
    end else if (state_q == ST_ACCESS && PREADY) begin
      tmo_q <= 1'b0;
    end else if (state_q == ST_ACCESS && tmo_hit) begin
      tmo_q <= 1'b1;
    end
  end

  assign rsp_timeout = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Next-state logic. RESP always returns to IDLE, so a new command can never
  // be accepted in the cycle a response retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || tmo_hit) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture; these registers drive the APB address/data lines
  // directly and hold their value outside a transfer.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state_q == ST_IDLE && req_valid) begin
      cap_write <= req_write;
      cap_addr  <= req_addr & ADDR_MASK;
      cap_wdata <= req_wdata;
    end
  end

  // Response registers load only at the end of ACCESS, so they are frozen
  // for the whole time rsp_valid is high.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == ST_ACCESS && PREADY) begin
      rdata_q <= cap_write ? '0 : PRDATA;
      err_q   <= PSLVERR;
    end else if (state_q == ST_ACCESS && tmo_hit) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  // Control outputs decode straight from the state register, which makes
  // them drop asynchronously with reset and keeps input-to-output paths out.
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PWRITE    = cap_write;
  assign PADDR     = cap_addr;
  assign PWDATA    = cap_wdata;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Self-checking bench for apb_cmd_master. A small APB slave model supplies
// PREADY wait states, PRDATA and PSLVERR. Each command pushes its expected
// response into a queue; an independent monitor pops and compares whenever a
// response handshake happens. The stimulus task also checks APB phase timing,
// address/data, response latency and backpressure behaviour.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        PCLK;
  logic        PRESETN;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int          total;
  int          bad;
  rsp_t        exp_q[$];

  int          slave_waits;
  int          slave_wcnt;
  logic [31:0] slave_prdata;
  logic        slave_err;

  apb_cmd_master #(
    .ADDR_W(8),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(PCLK),
    .PRESETN(PRESETN),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .busy(busy),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign PRDATA  = slave_prdata;
  assign PSLVERR = slave_err;

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // APB slave model: PREADY is driven for the coming edge based on how many
  // ACCESS cycles have already been stalled.
  initial begin
    PREADY     = 1'b0;
    slave_wcnt = 0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (slave_wcnt < slave_waits) begin
          PREADY = 1'b0;
          slave_wcnt++;
        end else begin
          PREADY = 1'b1;
        end
      end else begin
        PREADY     = 1'b0;
        slave_wcnt = 0;
      end
    end
  end

  // Scoreboard monitor: runs just after the falling edge so it sees the
  // rsp_ready value the stimulus has settled on for the next rising edge.
  initial begin
    rsp_t e;
    forever begin
      @(negedge PCLK);
      #1;
      if (PRESETN && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_output("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("sb_rdata", rsp_rdata, e.rdata);
          check_output("sb_err", 32'(rsp_err), 32'(e.err));
          check_output("sb_timeout", 32'(rsp_timeout), 32'(e.tmo));
        end
      end
    end
  end

  task automatic wait_req_ready();
    int n;
    n = 0;
    @(negedge PCLK);
    while (!req_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check_output("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One command end to end. k counts falling edges after the accept edge, so
  // k=1 is SETUP, k=2 the first ACCESS cycle.
  task automatic apply_stimulus(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                                input int waits, input logic [31:0] prdata, input bit err,
                                input bit tmo, input int lat, input int hold);
    rsp_t        e;
    logic [7:0]  exp_addr;
    int          k;
    exp_addr = {addr[7:2], 2'b00};
    wait_req_ready();
    slave_waits  = waits;
    slave_prdata = prdata;
    slave_err    = err;
    rsp_ready    = (hold == 0);
    if (tmo) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.tmo   = 1'b1;
    end else begin
      e.rdata = wr ? 32'h0 : prdata;
      e.err   = err;
      e.tmo   = 1'b0;
    end
    exp_q.push_back(e);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge PCLK);
    k = 1;
    req_valid = 1'b0;
    check_output("setup_psel_penable", 32'({PSEL, PENABLE}), 32'd2);
    check_output("setup_paddr", 32'(PADDR), 32'(exp_addr));
    check_output("setup_pwrite", 32'(PWRITE), 32'(wr));
    check_output("setup_pwdata", PWDATA, wdata);
    @(negedge PCLK);
    k = 2;
    check_output("access_psel_penable", 32'({PSEL, PENABLE}), 32'd3);
    while (!rsp_valid && k < 60) begin
      if (PENABLE) check_output("access_paddr_hold", 32'(PADDR), 32'(exp_addr));
      @(negedge PCLK);
      k++;
    end
    check_output("rsp_latency", 32'(k), 32'(lat));
    check_output("rsp_psel_low", 32'({PSEL, PENABLE}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h50;
      check_output("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("bp_rsp_rdata", rsp_rdata, e.rdata);
      check_output("bp_req_ready", 32'(req_ready), 32'd0);
      check_output("bp_no_psel", 32'(PSEL), 32'd0);
      @(negedge PCLK);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    check_output("post_rsp_req_ready", 32'(req_ready), 32'd1);
    check_output("post_rsp_valid_low", 32'(rsp_valid), 32'd0);
  endtask

  // Starts a read that the slave never completes, confirms the APB phase is
  // still held after `stall` extra cycles, then pulls reset mid-ACCESS.
  task automatic stall_and_reset(input int stall);
    wait_req_ready();
    slave_waits  = 1000000;
    slave_prdata = 32'h77778888;
    slave_err    = 1'b0;
    rsp_ready    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 8'h30;
    req_wdata    = 32'h0;
    req_valid    = 1'b1;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    repeat (stall) @(negedge PCLK);
    check_output("stall_psel_penable", 32'({PSEL, PENABLE}), 32'd3);
    #2;
    PRESETN = 1'b0;
    #1;
    check_output("async_rst_psel_penable", 32'({PSEL, PENABLE}), 32'd0);
    check_output("async_rst_busy", 32'(busy), 32'd0);
    check_output("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("async_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge PCLK);
    slave_waits = 0;
    PRESETN     = 1'b1;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    PRESETN      = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 8'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b1;
    slave_waits  = 0;
    slave_prdata = 32'h0;
    slave_err    = 1'b0;
    #3;
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_psel_penable_pwrite", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
    check_output("rst_paddr", 32'(PADDR), 32'd0);
    check_output("rst_pwdata", PWDATA, 32'd0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_output("rst_rsp_err_tmo", 32'({rsp_err, rsp_timeout}), 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETN = 1'b1;

    $display("[TB] write 0x13, no wait states");
    apply_stimulus(1'b1, 8'h13, 32'hDEADBEEF, 0, 32'h11112222, 1'b0, 1'b0, 3, 0);
    $display("[TB] read 0x04, three wait states");
    apply_stimulus(1'b0, 8'h04, 32'h0, 3, 32'hA5A50001, 1'b0, 1'b0, 6, 0);
    $display("[TB] read 0x2A with PSLVERR");
    apply_stimulus(1'b0, 8'h2A, 32'h0, 0, 32'h12345678, 1'b1, 1'b0, 3, 0);
    $display("[TB] read 0x08 under 10 cycles of response backpressure");
    apply_stimulus(1'b0, 8'h08, 32'h0, 1, 32'hCAFEF00D, 1'b0, 1'b0, 4, 10);
    $display("[TB] write 0xFF with PSLVERR");
    apply_stimulus(1'b1, 8'hFF, 32'h01020304, 2, 32'h99999999, 1'b1, 1'b0, 5, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    $display("[TB] read 0x40 with a stalled slave, expecting timeout");
    apply_stimulus(1'b0, 8'h40, 32'h0, 1000000, 32'h5555AAAA, 1'b0, 1'b1, 7, 0);
    $display("[TB] reset during ACCESS");
    stall_and_reset(2);
`else
    $display("[TB] stalled slave held for 100 cycles, then reset during ACCESS");
    stall_and_reset(100);
`endif

    $display("[TB] fresh write after reset");
    apply_stimulus(1'b1, 8'h21, 32'h0BADF00D, 0, 32'h0, 1'b0, 1'b0, 3, 0);

    repeat (3) @(negedge PCLK);
    check_output("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
